// File: rtl/cic_pdm_decim.sv
// cic_pdm_decim: N-order CIC decimator for 1..2 PDM microphones.
// Runs on the system clock with per-channel sample strobes, a runtime decimation ratio
// latched on the rising edge of enable, automatic gain normalisation with saturation,
// and a valid/ready output fed from one holding register per channel.
// Optional feature: define DC_REMOVAL_EN to add a per-channel leaky DC estimator after
// scaling (one extra pipeline cycle). Without it, dc_shift is ignored.
module cic_pdm_decim #(
    parameter int unsigned ORDER          = 3,
    parameter int unsigned CHANNELS       = 1,
    parameter int unsigned MAX_DECIM_LOG2 = 7,
    parameter int unsigned OUT_W          = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [3:0]                 decim_log2,
    input  logic [CHANNELS-1:0]        pdm_in,
    input  logic [CHANNELS-1:0]        pdm_stb,
    input  logic [3:0]                 dc_shift,
    output logic signed [OUT_W-1:0]    pcm_data,
    output logic                       pcm_chan,
    output logic                       pcm_valid,
    input  logic                       pcm_ready,
    output logic [CHANNELS-1:0]        overrun,
    input  logic                       ovr_clr
);

    // Integrator/comb width covers the largest gain R^ORDER plus sign.
    localparam int unsigned W   = ORDER * MAX_DECIM_LOG2 + 1;
    // Extended width leaves headroom for the left shift used when G < OUT_W.
    localparam int unsigned EW  = W + OUT_W;
    localparam int unsigned CW  = MAX_DECIM_LOG2;
    localparam int unsigned WUW = $clog2(ORDER + 1);

    localparam logic [3:0]           DMIN       = 4'd4;
    localparam logic [3:0]           DMAX       = 4'(MAX_DECIM_LOG2);
    localparam logic [WUW-1:0]       WARM_DONE  = WUW'(ORDER);
    localparam logic signed [W-1:0]  PLUS1      = W'(1);
    localparam logic signed [W-1:0]  MINUS1     = {W{1'b1}};

    // Whole datapath clears on reset or while disabled.
    logic clr;
    assign clr = rst || !enable;

    // ------------------------------------------------------------------
    // Decimation ratio latch
    // ------------------------------------------------------------------
    logic       en_q;
    logic [3:0] d_q;
    logic [3:0] d_clamped;
    logic [3:0] d_cur;
    logic [CW-1:0] term;

    always_comb begin
        if (decim_log2 < DMIN) begin
            d_clamped = DMIN;
        end else if (decim_log2 > DMAX) begin
            d_clamped = DMAX;
        end else begin
            d_clamped = decim_log2;
        end
        // Strobes in the enable-rise cycle already use the new ratio.
        d_cur = (enable && !en_q) ? d_clamped : d_q;
        term  = CW'((32'd1 << d_cur) - 32'd1);
    end

    // Track enable and latch the clamped ratio on its rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= 1'b0;
            d_q  <= DMIN;
        end else begin
            en_q <= enable;
            if (enable && !en_q) begin
                d_q <= d_clamped;
            end
        end
    end

    // ------------------------------------------------------------------
    // Integrators and decimation counters
    // ------------------------------------------------------------------
    logic signed [W-1:0] integ_q [CHANNELS][ORDER];
    logic [CW-1:0]       cnt_q   [CHANNELS];
    logic [CHANNELS-1:0] ev_q;

    // Integrator chains and strobe counters advance only on their channel's strobe
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ_q[c][k] <= '0;
                end
                cnt_q[c] <= '0;
            end
            ev_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                ev_q[c] <= pdm_stb[c] && (cnt_q[c] == term);
                if (pdm_stb[c]) begin
                    integ_q[c][0] <= integ_q[c][0] + (pdm_in[c] ? PLUS1 : MINUS1);
                    for (int k = 1; k < ORDER; k++) begin
                        integ_q[c][k] <= integ_q[c][k] + integ_q[c][k-1];
                    end
                    cnt_q[c] <= (cnt_q[c] == term) ? '0 : cnt_q[c] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Comb chain (pipeline stage 1)
    // ------------------------------------------------------------------
    logic signed [W-1:0] dly_q  [CHANNELS][ORDER];
    logic signed [W-1:0] comb_c [CHANNELS][ORDER];
    logic signed [W-1:0] comb_q [CHANNELS];
    logic [CHANNELS-1:0] comb_vld_q;

    // Differentiator cascade evaluated from the updated last integrator
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            comb_c[c][0] = integ_q[c][ORDER-1] - dly_q[c][0];
            for (int k = 1; k < ORDER; k++) begin
                comb_c[c][k] = comb_c[c][k-1] - dly_q[c][k];
            end
        end
    end

    // Register comb output and advance comb delays on each decimation event
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    dly_q[c][k] <= '0;
                end
                comb_q[c] <= '0;
            end
            comb_vld_q <= '0;
        end else begin
            comb_vld_q <= ev_q;
            for (int c = 0; c < CHANNELS; c++) begin
                if (ev_q[c]) begin
                    dly_q[c][0] <= integ_q[c][ORDER-1];
                    for (int k = 1; k < ORDER; k++) begin
                        dly_q[c][k] <= comb_c[c][k-1];
                    end
                    comb_q[c] <= comb_c[c][ORDER-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Gain normalisation and warm-up (pipeline stage 2)
    // ------------------------------------------------------------------
    function automatic logic signed [OUT_W-1:0] sat_scale(input logic signed [W-1:0] v,
                                                          input logic [3:0] d);
        logic signed [EW-1:0] ext;
        logic signed [EW-1:0] sh;
        int s;
        s   = int'(ORDER) * int'(d) + 1 - int'(OUT_W);
        ext = {{(EW-W){v[W-1]}}, v};
        sh  = (s >= 0) ? (ext >>> s) : (ext <<< (-s));
        if (sh[EW-1:OUT_W-1] == {(EW-OUT_W+1){sh[EW-1]}}) begin
            return sh[OUT_W-1:0];
        end else if (sh[EW-1]) begin
            return {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    logic signed [OUT_W-1:0] scaled [CHANNELS];
    logic [WUW-1:0]          warm_q [CHANNELS];
    logic [CHANNELS-1:0]     pass;

    // Scale every channel's comb result; only post-warm-up samples pass on
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            scaled[c] = sat_scale(comb_q[c], d_q);
            pass[c]   = comb_vld_q[c] && (warm_q[c] == WARM_DONE);
        end
    end

    // Count discarded settling outputs after each enable/reset
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                warm_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (comb_vld_q[c] && (warm_q[c] != WARM_DONE)) begin
                    warm_q[c] <= warm_q[c] + 1'b1;
                end
            end
        end
    end

    logic signed [OUT_W-1:0] new_data [CHANNELS];
    logic [CHANNELS-1:0]     new_vld;

`ifdef DC_REMOVAL_EN
    // ------------------------------------------------------------------
    // Leaky DC estimator (pipeline stage 3)
    // ------------------------------------------------------------------
    localparam int unsigned AW = OUT_W + 15;

    function automatic logic signed [OUT_W-1:0] sat_dc(input logic signed [AW:0] v);
        if (v[AW:OUT_W-1] == {(AW-OUT_W+2){v[AW]}}) begin
            return v[OUT_W-1:0];
        end else if (v[AW]) begin
            return {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    logic signed [AW-1:0]    acc_q   [CHANNELS];
    logic signed [OUT_W-1:0] sc_q    [CHANNELS];
    logic [CHANNELS-1:0]     sc_vld_q;
    logic signed [AW-1:0]    dc_est  [CHANNELS];
    logic signed [AW:0]      dc_diff [CHANNELS];

    // Subtract the pre-update DC estimate; shift 0 passes the sample through
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            dc_est[c]  = acc_q[c] >>> dc_shift;
            dc_diff[c] = {{(AW+1-OUT_W){sc_q[c][OUT_W-1]}}, sc_q[c]}
                         - {dc_est[c][AW-1], dc_est[c]};
            new_data[c] = (dc_shift == 4'd0) ? sc_q[c] : sat_dc(dc_diff[c]);
        end
        new_vld = sc_vld_q;
    end

    // Register scaled samples and update the estimator on each passed sample
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= '0;
                sc_q[c]  <= '0;
            end
            sc_vld_q <= '0;
        end else begin
            sc_vld_q <= pass;
            for (int c = 0; c < CHANNELS; c++) begin
                if (pass[c]) begin
                    sc_q[c] <= scaled[c];
                end
                if (sc_vld_q[c] && (dc_shift != 4'd0)) begin
                    acc_q[c] <= acc_q[c] + dc_diff[c][AW-1:0];
                end
            end
        end
    end
`else
    logic unused_dc;
    assign unused_dc = ^dc_shift;

    // Scaled sample goes straight to the holding register
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            new_data[c] = scaled[c];
        end
        new_vld = pass;
    end
`endif

    // ------------------------------------------------------------------
    // Holding registers and output arbitration
    // ------------------------------------------------------------------
    logic signed [OUT_W-1:0] hold_q [CHANNELS];
    logic [CHANNELS-1:0]     hold_full_q;
    logic                    lock_q;
    logic                    sel_q;
    logic                    cur;
    logic [CHANNELS-1:0]     take;
    logic [CHANNELS-1:0]     drop;
    logic [CHANNELS-1:0]     overrun_q;

    // Fixed priority to channel 0, but a stalled presentation stays locked in place
    always_comb begin
        cur = 1'b0;
        if (lock_q) begin
            cur = sel_q;
        end else if ((CHANNELS > 1) && !hold_full_q[0] && hold_full_q[CHANNELS-1]) begin
            cur = 1'b1;
        end
        pcm_valid = |hold_full_q;
        pcm_chan  = cur;
        pcm_data  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cur == 1'(c)) begin
                pcm_data = hold_q[c];
            end
            take[c] = pcm_valid && pcm_ready && (cur == 1'(c));
            // A slot being drained this cycle can accept the new sample
            drop[c] = enable && new_vld[c] && hold_full_q[c] && !take[c];
        end
    end

    // Load holding registers from the pipeline and release them on transfer
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                hold_q[c] <= '0;
            end
            hold_full_q <= '0;
            lock_q      <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            lock_q <= pcm_valid && !pcm_ready;
            sel_q  <= cur;
            for (int c = 0; c < CHANNELS; c++) begin
                if (new_vld[c] && (!hold_full_q[c] || take[c])) begin
                    hold_q[c]      <= new_data[c];
                    hold_full_q[c] <= 1'b1;
                end else if (take[c]) begin
                    hold_full_q[c] <= 1'b0;
                end
            end
        end
    end

    // Sticky drop flags; survive enable=0, and a new set beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= (ovr_clr ? '0 : overrun_q) | drop;
        end
    end

    assign overrun = overrun_q;

endmodule
